// File: rtl/rti_unit.sv
// ---------------------------------------------------------------------------
// rti_unit -- return-from-interrupt sequencer
//
// Unwinds the interrupt entry sequence. When decode presents an RTI, fetch is
// stalled and three POP instructions are injected in reverse push order:
// PC high, PC low, then CCR. The words those POPs write back are captured
// from the writeback bus in any order. Once all three have been seen, the
// 32-bit PC and the CCR are presented together with one-cycle load strobes,
// so the interrupted program resumes.
//
// Optional feature macro: RTI_TIMEOUT_EN
//   defined   : WAIT_WB gives up after WB_TIMEOUT cycles with an incomplete
//               capture set, raises the sticky err flag and returns to IDLE
//               without load strobes.
//   undefined : WAIT_WB waits indefinitely, no counter exists, err is 0.
//
// Parameters
//   CCR_W       width of the restored condition-code register
//   WB_TIMEOUT  WAIT_WB cycle budget (RTI_TIMEOUT_EN only)
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   enable       block enable; 0 returns to IDLE and clears captures
//   rti_req      RTI present in decode (sampled in IDLE only)
//   wb_valid     writeback stage writes a register this cycle
//   wb_reg_id    writeback destination (PCL=8, PCH=9, CCR=10)
//   wb_data      writeback data
//   stall        hold fetch / PC
//   inject       instruction replaces the fetched word
//   instruction  injected instruction
//   PC_VALUE     restored PC {pc_hi, pc_lo}
//   pc_load      one-cycle strobe: load PC_VALUE
//   ccr_value    restored CCR
//   ccr_load     one-cycle strobe: load ccr_value
//   busy         sequence in progress
//   err          sticky writeback-timeout flag
// ---------------------------------------------------------------------------
module rti_unit #(
  parameter int CCR_W      = 4,
  parameter int WB_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             rti_req,
  input  logic             wb_valid,
  input  logic [3:0]       wb_reg_id,
  input  logic [15:0]      wb_data,
  output logic             stall,
  output logic             inject,
  output logic [15:0]      instruction,
  output logic [31:0]      PC_VALUE,
  output logic             pc_load,
  output logic [CCR_W-1:0] ccr_value,
  output logic             ccr_load,
  output logic             busy,
  output logic             err
);

  localparam logic [15:0] OP_NOP     = 16'h0000;
  localparam logic [15:0] OP_POP_PCH = 16'h7009;
  localparam logic [15:0] OP_POP_PCL = 16'h7008;
  localparam logic [15:0] OP_POP_CCR = 16'h700A;

  localparam logic [3:0] ID_PCL = 4'd8;
  localparam logic [3:0] ID_PCH = 4'd9;
  localparam logic [3:0] ID_CCR = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_POP_PCH,
    S_POP_PCL,
    S_POP_CCR,
    S_WAIT_WB,
    S_RESTORE
  } state_t;

  state_t state_reg, state_next;

  // Captured words and the got mask: bit2 = PC high, bit1 = PC low, bit0 = CCR
  logic [15:0]      pc_hi_reg, pc_hi_next;
  logic [15:0]      pc_lo_reg, pc_lo_next;
  logic [CCR_W-1:0] ccr_cap_reg, ccr_cap_next;
  logic [2:0]       got_reg, got_next;

  // Output registers
  logic             stall_reg, inject_reg, busy_reg, pc_load_reg, ccr_load_reg;
  logic [15:0]      instr_reg;
  logic [31:0]      pc_value_reg;
  logic [CCR_W-1:0] ccr_value_reg;

  // Output decode of the state being entered
  logic             stall_d, inject_d, busy_d, load_d;
  logic [15:0]      instr_d;

  logic             timeout_hit;

  // -------------------------------------------------------------------------
  // Capture path. Writebacks can overlap the POP injection itself, so capture
  // is live in every state but IDLE. The combinational next values are used
  // by the FSM so that the third capture and the move to RESTORE share an
  // edge.
  // -------------------------------------------------------------------------
  always_comb begin
    pc_hi_next   = pc_hi_reg;
    pc_lo_next   = pc_lo_reg;
    ccr_cap_next = ccr_cap_reg;
    got_next     = got_reg;
    if (state_reg == S_IDLE) begin
      if (rti_req) begin
        got_next = 3'b000;
      end
    end else if (wb_valid) begin
      case (wb_reg_id)
        ID_PCH: begin
          pc_hi_next  = wb_data;
          got_next[2] = 1'b1;
        end
        ID_PCL: begin
          pc_lo_next  = wb_data;
          got_next[1] = 1'b1;
        end
        ID_CCR: begin
          ccr_cap_next = wb_data[CCR_W-1:0];
          got_next[0]  = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef RTI_TIMEOUT_EN
  localparam int CNT_W = $clog2(WB_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WB_TIMEOUT - 1);

  // Counts cycles already spent in WAIT_WB; zero on the first WAIT_WB cycle.
  logic [CNT_W-1:0] wait_cnt_reg;
  logic             err_reg;
`endif

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next  = state_reg;
    timeout_hit = 1'b0;
    case (state_reg)
      S_IDLE:    if (rti_req) state_next = S_DRAIN;
      S_DRAIN:   state_next = S_POP_PCH;
      S_POP_PCH: state_next = S_POP_PCL;
      S_POP_PCL: state_next = S_POP_CCR;
      S_POP_CCR: state_next = S_WAIT_WB;
      S_WAIT_WB: begin
        if (got_next == 3'b111) begin
          state_next = S_RESTORE;
        end
`ifdef RTI_TIMEOUT_EN
        else if (wait_cnt_reg == CNT_LAST) begin
          // Budget exhausted on this cycle: abandon without loading anything.
          state_next  = S_IDLE;
          timeout_hit = 1'b1;
        end
`endif
      end
      S_RESTORE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode. Outputs are registered from the state being entered, so
  // each output register always reflects the current state.
  // -------------------------------------------------------------------------
  always_comb begin
    stall_d  = 1'b0;
    inject_d = 1'b0;
    busy_d   = 1'b1;
    load_d   = 1'b0;
    instr_d  = OP_NOP;
    case (state_next)
      S_IDLE:    busy_d = 1'b0;
      S_DRAIN:   stall_d = 1'b1;
      S_POP_PCH: begin
        stall_d  = 1'b1;
        inject_d = 1'b1;
        instr_d  = OP_POP_PCH;
      end
      S_POP_PCL: begin
        stall_d  = 1'b1;
        inject_d = 1'b1;
        instr_d  = OP_POP_PCL;
      end
      S_POP_CCR: begin
        stall_d  = 1'b1;
        inject_d = 1'b1;
        instr_d  = OP_POP_CCR;
      end
      S_WAIT_WB: stall_d = 1'b1;
      S_RESTORE: load_d = 1'b1;
      default:   busy_d = 1'b0;
    endcase
  end

  // -------------------------------------------------------------------------
  // State, capture and output registers. enable=0 behaves like reset except
  // that the sticky err flag survives.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      state_reg     <= S_IDLE;
      pc_hi_reg     <= '0;
      pc_lo_reg     <= '0;
      ccr_cap_reg   <= '0;
      got_reg       <= '0;
      stall_reg     <= 1'b0;
      inject_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      pc_load_reg   <= 1'b0;
      ccr_load_reg  <= 1'b0;
      instr_reg     <= OP_NOP;
      pc_value_reg  <= '0;
      ccr_value_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pc_hi_reg    <= pc_hi_next;
      pc_lo_reg    <= pc_lo_next;
      ccr_cap_reg  <= ccr_cap_next;
      got_reg      <= got_next;
      stall_reg    <= stall_d;
      inject_reg   <= inject_d;
      busy_reg     <= busy_d;
      pc_load_reg  <= load_d;
      ccr_load_reg <= load_d;
      instr_reg    <= instr_d;
      // Restored values latch only on entry to RESTORE and then hold.
      if (state_next == S_RESTORE && state_reg != S_RESTORE) begin
        pc_value_reg  <= {pc_hi_next, pc_lo_next};
        ccr_value_reg <= ccr_cap_next;
      end
    end
  end

`ifdef RTI_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else if (!enable) begin
      wait_cnt_reg <= '0;
    end else begin
      // Zero whenever outside WAIT_WB, so it is clear on every entry.
      if (state_next == S_WAIT_WB && state_reg == S_WAIT_WB) begin
        wait_cnt_reg <= wait_cnt_reg + 1'b1;
      end else begin
        wait_cnt_reg <= '0;
      end
      if (timeout_hit) begin
        err_reg <= 1'b1;
      end
    end
  end

  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  assign stall       = stall_reg;
  assign inject      = inject_reg;
  assign instruction = instr_reg;
  assign PC_VALUE    = pc_value_reg;
  assign pc_load     = pc_load_reg;
  assign ccr_value   = ccr_value_reg;
  assign ccr_load    = ccr_load_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_rti_unit.sv
// Directed bench for rti_unit. Inputs change 1 time unit after a rising edge
// and outputs are sampled there too, so each tick() lands in the next cycle.
module tb_rti_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        rti_req;
  logic        wb_valid;
  logic [3:0]  wb_reg_id;
  logic [15:0] wb_data;
  logic        stall;
  logic        inject;
  logic [15:0] instruction;
  logic [31:0] PC_VALUE;
  logic        pc_load;
  logic [3:0]  ccr_value;
  logic        ccr_load;
  logic        busy;
  logic        err;

  int pass_cnt  = 0;
  int check_cnt = 0;

  always #5 clk = ~clk;

  rti_unit #(.CCR_W(4), .WB_TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .enable(enable), .rti_req(rti_req),
    .wb_valid(wb_valid), .wb_reg_id(wb_reg_id), .wb_data(wb_data),
    .stall(stall), .inject(inject), .instruction(instruction),
    .PC_VALUE(PC_VALUE), .pc_load(pc_load), .ccr_value(ccr_value),
    .ccr_load(ccr_load), .busy(busy), .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-26s observed=%h expected=%h", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compact view of the control outputs: {stall, inject, busy, pc_load, ccr_load}
  function automatic logic [4:0] ctl();
    return {stall, inject, busy, pc_load, ccr_load};
  endfunction

  task automatic wb(input logic [3:0] id, input logic [15:0] data);
    wb_valid  = 1'b1;
    wb_reg_id = id;
    wb_data   = data;
  endtask

  task automatic wb_idle();
    wb_valid  = 1'b0;
    wb_reg_id = 4'd0;
    wb_data   = 16'h0000;
  endtask

  // Pulses rti_req in cycle 0 and walks to cycle 5 (WAIT_WB) checking the
  // injected POP sequence on the way.
  task automatic start_seq(input string nm, input logic hold_req);
    rti_req = 1'b1;
    tick();                               // c1 DRAIN
    if (!hold_req) rti_req = 1'b0;
    check({nm, "_c1_ctl"}, 32'(ctl()), 32'b10100);
    check({nm, "_c1_instr"}, 32'(instruction), 32'h0000);
    tick();                               // c2 POP_PCH
    check({nm, "_c2_ctl"}, 32'(ctl()), 32'b11100);
    check({nm, "_c2_instr"}, 32'(instruction), 32'h7009);
    tick();                               // c3 POP_PCL
    check({nm, "_c3_instr"}, 32'(instruction), 32'h7008);
    tick();                               // c4 POP_CCR
    check({nm, "_c4_instr"}, 32'(instruction), 32'h700A);
    tick();                               // c5 WAIT_WB
    check({nm, "_c5_ctl"}, 32'(ctl()), 32'b10100);
    check({nm, "_c5_instr"}, 32'(instruction), 32'h0000);
  endtask

  initial begin
    reset    = 1'b0;
    enable   = 1'b1;
    rti_req  = 1'b0;
    wb_idle();
    tick();
    tick();

    // ---- reset state
    check("rst_ctl", 32'(ctl()), 32'b00000);
    check("rst_instr", 32'(instruction), 32'h0000);
    check("rst_pc", PC_VALUE, 32'h0);
    check("rst_ccr", 32'(ccr_value), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    reset = 1'b1;
    tick();

    // ---- normal in-order sequence: id9 c6, id8 c7, id10 c8 -> RESTORE c9
    start_seq("norm", 1'b0);
    tick();                               // c6
    wb(4'd9, 16'h0001);
    tick();                               // c7
    wb(4'd8, 16'h2340);
    check("norm_c7_noload", 32'(ctl()), 32'b10100);
    tick();                               // c8
    wb(4'd10, 16'h000B);
    check("norm_c8_noload", 32'(ctl()), 32'b10100);
    tick();                               // c9 RESTORE
    wb_idle();
    check("norm_c9_ctl", 32'(ctl()), 32'b00111);
    check("norm_c9_pc", PC_VALUE, 32'h00012340);
    check("norm_c9_ccr", 32'(ccr_value), 32'hB);
    tick();                               // c10 IDLE
    check("norm_c10_ctl", 32'(ctl()), 32'b00000);
    check("norm_c10_pc_hold", PC_VALUE, 32'h00012340);
    tick();

    // ---- out of order id10, id8, id9 plus an ignored id and an overwrite
    start_seq("ooo", 1'b0);
    wb(4'd3, 16'hFFFF);                   // c5: not a captured id
    tick();                               // c6
    wb(4'd10, 16'h0005);
    tick();                               // c7
    wb(4'd8, 16'h1111);
    tick();                               // c8: PC low overwritten
    wb(4'd8, 16'hBEEF);
    check("ooo_c8_noload", 32'(ctl()), 32'b10100);
    tick();                               // c9
    wb(4'd9, 16'hCAFE);
    check("ooo_c9_noload", 32'(ctl()), 32'b10100);
    tick();                               // c10 RESTORE
    wb_idle();
    check("ooo_c10_ctl", 32'(ctl()), 32'b00111);
    check("ooo_c10_pc", PC_VALUE, 32'hCAFEBEEF);
    check("ooo_c10_ccr", 32'(ccr_value), 32'h5);
    tick();

    // ---- rti_req held high: one sequence, then IDLE re-samples it
    start_seq("held", 1'b1);
    wb(4'd9, 16'h0001);                   // c5
    tick();
    wb(4'd8, 16'h2340);                   // c6
    tick();
    wb(4'd10, 16'h000B);                  // c7
    tick();                               // c8 RESTORE
    wb_idle();
    check("held_c8_ctl", 32'(ctl()), 32'b00111);
    check("held_c8_pc", PC_VALUE, 32'h00012340);
    tick();                               // c9 IDLE
    check("held_c9_ctl", 32'(ctl()), 32'b00000);
    tick();                               // c10 DRAIN of a new sequence
    rti_req = 1'b0;
    check("held_c10_ctl", 32'(ctl()), 32'b10100);
    tick(); tick(); tick(); tick();       // c14 WAIT_WB

    // ---- enable=0 in WAIT_WB aborts without strobes
    check("en_wait_ctl", 32'(ctl()), 32'b10100);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("en_abort_ctl", 32'(ctl()), 32'b00000);
    check("en_abort_pc", PC_VALUE, 32'h0);
    tick();
    start_seq("en_re", 1'b0);
    wb(4'd10, 16'h0007);
    tick();
    wb(4'd9, 16'h00A5);
    tick();
    wb(4'd8, 16'h5A00);
    tick();                               // RESTORE
    wb_idle();
    check("en_re_ctl", 32'(ctl()), 32'b00111);
    check("en_re_pc", PC_VALUE, 32'h00A55A00);
    check("en_re_ccr", 32'(ccr_value), 32'h7);
    tick();

    // ---- reset during POP_PCL: abort, reset values, no strobe ever
    rti_req = 1'b1;
    tick();                               // c1
    rti_req = 1'b0;
    tick();                               // c2
    tick();                               // c3 POP_PCL
    check("rmid_c3_instr", 32'(instruction), 32'h7008);
    reset = 1'b0;
    tick();                               // c4
    reset = 1'b1;
    check("rmid_ctl", 32'(ctl()), 32'b00000);
    check("rmid_instr", 32'(instruction), 32'h0000);
    check("rmid_pc", PC_VALUE, 32'h0);
    check("rmid_ccr", 32'(ccr_value), 32'h0);
    wb(4'd9, 16'h1234);
    tick();
    wb(4'd8, 16'h5678);
    tick();
    wb(4'd10, 16'h0003);
    for (int i = 0; i < 4; i++) begin
      tick();
      wb_idle();
      check("rmid_noload", 32'(ctl()), 32'b00000);
    end

    // ---- only PC words written: timeout (feature on) or wait forever
    start_seq("to", 1'b0);
    wb(4'd9, 16'h0001);                   // c5
    tick();
    wb(4'd8, 16'h2340);                   // c6
    tick();
    wb_idle();
    for (int i = 7; i < 19; i++) tick(); // c19: 15th WAIT_WB cycle
    check("to_c19_ctl", 32'(ctl()), 32'b10100);
    check("to_c19_err", 32'(err), 32'h0);
    tick();                               // c20
`ifdef RTI_TIMEOUT_EN
    check("to_c20_ctl", 32'(ctl()), 32'b00000);
    check("to_c20_err", 32'(err), 32'h1);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("to_err_sticky_en", 32'(err), 32'h1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("to_err_rst", 32'(err), 32'h0);
`else
    check("to_c20_wait", 32'(ctl()), 32'b10100);
    check("to_c20_err", 32'(err), 32'h0);
    enable = 1'b0;
    tick();
    enable = 1'b1;
    check("to_abort_ctl", 32'(ctl()), 32'b00000);
`endif
    tick();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
